mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: ADDR_W, 32, width of the RAM-side byte address mem_a_o.
REQ-002 clk_in  input  1  the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ram_r_req_i  input  1  data-port read request, level, held until done.
REQ-005 ram_w_req_i  input  1  data-port write request, level, held until done.
REQ-006 ram_addr_i  input  32  data-port byte address.
REQ-007 ram_w_data_i  input  32  data-port write data; bytes taken LSB-first.
REQ-008 ram_state_i  input  2  access size: 2'b00 byte, 2'b01 half, 2'b11 word; 2'b10 treated as byte.
REQ-009 ram_done_o  output  1  data-port completion, one-cycle pulse.
REQ-010 ram_r_data_o  output  32  data-port read data, zero-extended.
REQ-011 if_req_i  input  1  fetch-port read request, level, always word size.
REQ-012 if_addr_i  input  32  fetch-port byte address.
REQ-013 if_done_o  output  1  fetch-port completion, one-cycle pulse.
REQ-014 if_data_o  output  32  fetched instruction word.
REQ-015 mem_din_i  input  8  RAM read byte, valid the cycle after its address.
REQ-016 mem_dout_o  output  8  RAM write byte.
REQ-017 mem_a_o  output  ADDR_W  RAM byte address.
REQ-018 mem_wr_o  output  1  RAM write strobe, 1 = write this cycle.

Function
REQ-019 States SHALL be IDLE, ADDR, WAIT, DONE; a 2-bit byte counter, a 2-bit last-byte index N-1, a port-select flag, and a latched address/write-data/size per transaction.
REQ-020 In IDLE, a request sampled at a rising edge SHALL be accepted (cycle 0); priority: ram_w_req_i, then ram_r_req_i, then if_req_i.
REQ-021 Both ram_r_req_i and ram_w_req_i high together SHALL be treated as a write.
REQ-022 Request inputs SHALL be ignored outside IDLE; address/data/size SHALL be latched at acceptance, so later input changes do not affect the transaction.
REQ-023 ADDR: cycle k (k=1..N) SHALL drive mem_a_o = addr+k-1 (truncated to ADDR_W, wrapping modulo 2^ADDR_W); N = 1/2/4 per size.
REQ-024 Writes: in ADDR SHALL drive mem_wr_o=1, mem_dout_o = w_data[8(k-1)+7 : 8(k-1)]; after cycle N go to DONE (done in cycle N+1).
REQ-025 Reads: mem_wr_o=0; byte at addr+j SHALL be captured from mem_din_i into bits [8j+7:8j] at the edge ending cycle j+2; after cycle N go to WAIT, then DONE (done in cycle N+2).
REQ-026 Read data register SHALL be cleared at acceptance; bytes above size remain 0.
REQ-027 DONE SHALL last exactly one cycle, raise only the selected port's done, then return to IDLE; a request present in that DONE cycle SHALL NOT be accepted until the following IDLE cycle.
REQ-028 ram_r_data_o / if_data_o SHALL hold their value from DONE until that port's next acceptance.
REQ-029 Outside ADDR: mem_wr_o=0, mem_a_o=0, mem_dout_o=0.
REQ-030 Latency summary: byte write 2, word write 5, byte read 3, word read 6 cycles from acceptance to done.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, counter 0, done outputs 0, mem_wr_o 0, mem_a_o 0, mem_dout_o 0, ram_r_data_o 0, if_data_o 0, independent of clk_in.
REQ-032 Reset asserted mid-transaction SHALL abort it with no done pulse; a write SHALL issue no further mem_wr_o cycles; first acceptance is possible at the first rising edge after release.

Verification
REQ-033 Word read at 0x100, RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 in cycles 1-4, ram_done_o high only in cycle 6, ram_r_data_o=0x44332211.
REQ-034 SB addr 0x2003, ram_w_data_i=0xAABBCCDD -> one cycle mem_wr_o=1, mem_a=0x2003, mem_dout=0xDD; done in cycle 2.
REQ-035 Half read 0x10, bytes 0x80,0xFF -> ram_r_data_o=0x0000FF80, done cycle 4; next word fetch keeps ram_r_data_o unchanged.
REQ-036 if_req_i and ram_r_req_i rise together -> data read served first, then fetch accepted in the IDLE cycle after DONE; each done pulses once.
REQ-037 rst_n low in cycle 2 of SW at 0x40 -> mem_wr_o drops at once, no done, only byte 0x40 written; next request after release completes normally.
REQ-038 Word write at 0xFFFFFFFE with ADDR_W=32 -> mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the core's data/fetch ports, the memory controller
// and the byte-wide RAM.
interface mem_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              ram_r_req_i;
   logic              ram_w_req_i;
   logic [31:0]       ram_addr_i;
   logic [31:0]       ram_w_data_i;
   logic [1:0]        ram_state_i;
   logic              ram_done_o;
   logic [31:0]       ram_r_data_o;
   logic              if_req_i;
   logic [31:0]       if_addr_i;
   logic              if_done_o;
   logic [31:0]       if_data_o;
   logic [7:0]        mem_din_i;
   logic [7:0]        mem_dout_o;
   logic [ADDR_W-1:0] mem_a_o;
   logic              mem_wr_o;

   modport slave (
      input  ram_r_req_i, ram_w_req_i, ram_addr_i,
      input  ram_w_data_i, ram_state_i,
      input  if_req_i, if_addr_i, mem_din_i,
      output ram_done_o, ram_r_data_o,
      output if_done_o, if_data_o,
      output mem_dout_o, mem_a_o, mem_wr_o
   );

   modport master (
      output ram_r_req_i, ram_w_req_i, ram_addr_i,
      output ram_w_data_i, ram_state_i,
      output if_req_i, if_addr_i, mem_din_i,
      input  ram_done_o, ram_r_data_o,
      input  if_done_o, if_data_o,
      input  mem_dout_o, mem_a_o, mem_wr_o
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating the data port and the
// instruction-fetch port onto one 8-bit RAM.
module mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic       clk_in,
   input  logic       rst_n,
   mem_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      WAIT,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [1:0]  cnt;
   logic [1:0]  last;
   logic        sel_if;
   logic        wr_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_ram;
   logic [31:0] rdata_if;
   logic [31:0] a_sum;

   logic        acc_w;
   logic        acc_r;
   logic        acc_f;
   logic        accept;
   logic        cap_en;
   logic [1:0]  cap_idx;

   always_comb begin
      acc_w   = 1'b0;
      acc_r   = 1'b0;
      acc_f   = 1'b0;
      if (state == IDLE) begin
         acc_w = bus.ram_w_req_i;
         acc_r = !bus.ram_w_req_i && bus.ram_r_req_i;
         acc_f = !bus.ram_w_req_i && !bus.ram_r_req_i
               && bus.if_req_i;
      end
      accept  = acc_w | acc_r | acc_f;
      // A RAM byte shows up one cycle after its address, so the
      // capture lags the address phase by one cycle.
      cap_en  = !wr_q
              && ((state == ADDR && cnt != 2'd0) || state == WAIT);
      cap_idx = (state == WAIT) ? last : cnt - 2'd1;
      a_sum   = addr_q + {30'd0, cnt};
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = ADDR;
         ADDR: if (cnt == last) state_nx = wr_q ? DONE : WAIT;
         WAIT: state_nx = DONE;
         DONE: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= 2'd0;
         last      <= 2'd0;
         sel_if    <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         rdata_ram <= 32'd0;
         rdata_if  <= 32'd0;
      end else begin
         if (accept) begin
            cnt     <= 2'd0;
            wr_q    <= acc_w;
            sel_if  <= acc_f;
            wdata_q <= bus.ram_w_data_i;
            if (acc_f) begin
               addr_q   <= bus.if_addr_i;
               last     <= 2'd3;
               rdata_if <= 32'd0;
            end else begin
               addr_q    <= bus.ram_addr_i;
               // 00 byte, 01 half, 11 word, 10 falls back to byte
               last      <= {bus.ram_state_i[1] & bus.ram_state_i[0],
                             bus.ram_state_i[0]};
               rdata_ram <= 32'd0;
            end
         end else if (state == ADDR) begin
            cnt <= cnt + 2'd1;
         end
         if (cap_en) begin
            if (sel_if)
               rdata_if[{cap_idx, 3'b000} +: 8] <= bus.mem_din_i;
            else
               rdata_ram[{cap_idx, 3'b000} +: 8] <= bus.mem_din_i;
         end
      end
   end

   always_comb begin
      bus.mem_a_o      = '0;
      bus.mem_wr_o     = 1'b0;
      bus.mem_dout_o   = 8'd0;
      bus.ram_done_o   = 1'b0;
      bus.if_done_o    = 1'b0;
      bus.ram_r_data_o = rdata_ram;
      bus.if_data_o    = rdata_if;
      unique case (1'b1)
         (state == ADDR): begin
            bus.mem_a_o  = a_sum[ADDR_W-1:0];
            bus.mem_wr_o = wr_q;
            if (wr_q)
               bus.mem_dout_o = wdata_q[{cnt, 3'b000} +: 8];
         end
         (state == DONE): begin
            bus.ram_done_o = !sel_if;
            bus.if_done_o  = sel_if;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and random bench for mem_ctrl with a 4 KB mirrored byte RAM
// and a transaction-level reference memory.
module tb_mem_ctrl;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b1;
   always #5 clk_in = ~clk_in;

   mem_ctrl_if #(.ADDR_W(32)) bus ();

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus.slave)
   );

   logic [7:0]  ram [4096];
   logic [7:0]  ref_mem [4096];
   logic        fill  = 1'b1;
   logic        pl_en = 1'b0;
   logic [11:0] pl_a  = 12'd0;
   logic [7:0]  pl_d  = 8'd0;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_rd;
   logic [31:0] exp_if;
   bit          rd_ok;

   function automatic logic [7:0] pat(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], 4'h0} ^ 8'h5A;
   endfunction

   always @(posedge clk_in) begin
      if (fill)
         for (int i = 0; i < 4096; i++) ram[i] <= pat(12'(i));
      else if (pl_en)
         ram[pl_a] <= pl_d;
      else if (bus.mem_wr_o)
         ram[bus.mem_a_o[11:0]] <= bus.mem_dout_o;
      bus.mem_din_i <= ram[bus.mem_a_o[11:0]];
   end

   function automatic logic [31:0] ref_word(input logic [31:0] a,
                                            input int n);
      logic [31:0] w;
      logic [11:0] i;
      w = 32'd0;
      for (int j = 0; j < n; j++) begin
         i = 12'(a + 32'(j));
         w = w | (32'(ref_mem[i]) << (8 * j));
      end
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [11:0] a, input logic [7:0] d);
      pl_a  = a;
      pl_d  = d;
      pl_en = 1'b1;
      @(posedge clk_in);
      #1;
      pl_en = 1'b0;
      ref_mem[a] = d;
   endtask

   // kind: 0 write, 1 read, 2 fetch, 3 read+write together
   task automatic run(input int kind, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] sz);
      int          n;
      int          lat;
      bit          is_wr;
      logic [31:0] exp;
      logic [11:0] ix;
      is_wr = (kind == 0) || (kind == 3);
      if (kind == 2)          n = 4;
      else if (sz == 2'b11)   n = 4;
      else if (sz == 2'b01)   n = 2;
      else                    n = 1;
      lat = is_wr ? n + 1 : n + 2;
      exp = ref_word(a, n);
      bus.ram_w_req_i  = is_wr;
      bus.ram_r_req_i  = (kind == 1) || (kind == 3);
      bus.if_req_i     = (kind == 2);
      bus.ram_addr_i   = a;
      bus.if_addr_i    = a;
      bus.ram_w_data_i = wd;
      bus.ram_state_i  = sz;
      for (int c = 1; c <= lat; c++) begin
         @(posedge clk_in);
         #1;
         if (c == 1) begin
            bus.ram_addr_i   = $urandom;
            bus.if_addr_i    = $urandom;
            bus.ram_w_data_i = $urandom;
            bus.ram_state_i  = 2'($urandom);
         end
         if (c <= n) begin
            check("addr", bus.mem_a_o, a + 32'(c - 1));
            check("wr", 32'(bus.mem_wr_o), 32'(is_wr));
            if (is_wr)
               check("dout", 32'(bus.mem_dout_o),
                     (wd >> (8 * (c - 1))) & 32'hFF);
         end else if (c < lat) begin
            check("wait_bus",
                  {bus.mem_a_o[22:0], bus.mem_dout_o, bus.mem_wr_o},
                  32'd0);
         end
         check("ram_done", 32'(bus.ram_done_o),
               32'(kind != 2 && c == lat));
         check("if_done", 32'(bus.if_done_o),
               32'(kind == 2 && c == lat));
      end
      bus.ram_w_req_i = 1'b0;
      bus.ram_r_req_i = 1'b0;
      bus.if_req_i    = 1'b0;
      if (is_wr) begin
         for (int j = 0; j < n; j++) begin
            ix = 12'(a + 32'(j));
            ref_mem[ix] = 8'((wd >> (8 * j)) & 32'hFF);
         end
         rd_ok = 1'b0;
      end else if (kind == 1) begin
         exp_rd = exp;
         rd_ok  = 1'b1;
      end else begin
         exp_if = exp;
      end
      if (rd_ok) check("ram_r_data", bus.ram_r_data_o, exp_rd);
      check("if_data", bus.if_data_o, exp_if);
      @(posedge clk_in);
      #1;
      check("idle", {29'd0, bus.ram_done_o, bus.if_done_o,
                     bus.mem_wr_o}, 32'd0);
   endtask

   initial begin
      logic [31:0] e1;
      logic [31:0] e2;
      bus.ram_r_req_i  = 1'b0;
      bus.ram_w_req_i  = 1'b0;
      bus.if_req_i     = 1'b0;
      bus.ram_addr_i   = 32'd0;
      bus.if_addr_i    = 32'd0;
      bus.ram_w_data_i = 32'd0;
      bus.ram_state_i  = 2'b00;
      for (int i = 0; i < 4096; i++) ref_mem[i] = pat(12'(i));
      exp_rd = 32'd0;
      exp_if = 32'd0;
      rd_ok  = 1'b1;

      #1 rst_n = 1'b0;
      #1;
      check("rst_a", bus.mem_a_o, 32'd0);
      check("rst_ctl", {22'd0, bus.mem_dout_o, bus.mem_wr_o,
                        bus.ram_done_o}, 32'd0);
      check("rst_ifdone", 32'(bus.if_done_o), 32'd0);
      check("rst_rdata", bus.ram_r_data_o, 32'd0);
      check("rst_ifdata", bus.if_data_o, 32'd0);
      repeat (2) @(posedge clk_in);
      #1;
      fill  = 1'b0;
      rst_n = 1'b1;

      preload(12'h100, 8'h11);
      preload(12'h101, 8'h22);
      preload(12'h102, 8'h33);
      preload(12'h103, 8'h44);
      run(1, 32'h100, 32'd0, 2'b11);
      check("lw_data", bus.ram_r_data_o, 32'h44332211);

      run(0, 32'h2003, 32'hAABBCCDD, 2'b00);
      check("sb_ram", 32'(ram[12'h003]), 32'hDD);
      check("sb_next", 32'(ram[12'h004]), 32'(pat(12'h004)));

      preload(12'h010, 8'h80);
      preload(12'h011, 8'hFF);
      run(1, 32'h10, 32'd0, 2'b01);
      check("lh_data", bus.ram_r_data_o, 32'h0000FF80);
      run(2, 32'h200, 32'd0, 2'b00);
      check("lh_hold", bus.ram_r_data_o, 32'h0000FF80);

      run(3, 32'h300, 32'h12345678, 2'b01);
      run(1, 32'h300, 32'd0, 2'b11);
      run(1, 32'h2003, 32'd0, 2'b10);
      check("sz10_data", bus.ram_r_data_o, 32'h000000DD);

      // data read and fetch raised together
      e1 = ref_word(32'h100, 4);
      e2 = ref_word(32'h2000, 4);
      bus.ram_addr_i  = 32'h100;
      bus.ram_state_i = 2'b11;
      bus.if_addr_i   = 32'h2000;
      bus.ram_r_req_i = 1'b1;
      bus.if_req_i    = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         @(posedge clk_in);
         #1;
         check("both_rdone", 32'(bus.ram_done_o), 32'(c == 6));
         check("both_idone", 32'(bus.if_done_o), 32'(c == 13));
         if (c == 6) begin
            bus.ram_r_req_i = 1'b0;
            check("both_rdata", bus.ram_r_data_o, e1);
         end
         if (c >= 8 && c <= 11)
            check("both_fa", bus.mem_a_o, 32'h2000 + 32'(c - 8));
      end
      bus.if_req_i = 1'b0;
      check("both_idata", bus.if_data_o, e2);
      check("both_rhold", bus.ram_r_data_o, e1);
      exp_rd = e1;
      exp_if = e2;
      rd_ok  = 1'b1;
      @(posedge clk_in);
      #1;

      // reset during the second beat of a word store
      bus.ram_addr_i   = 32'h40;
      bus.ram_w_data_i = 32'h11223344;
      bus.ram_state_i  = 2'b11;
      bus.ram_w_req_i  = 1'b1;
      @(posedge clk_in);
      #1;
      check("sw_c1", {bus.mem_a_o[30:0], bus.mem_wr_o}, 32'h81);
      @(posedge clk_in);
      #1;
      check("sw_c2", {bus.mem_a_o[30:0], bus.mem_wr_o}, 32'h83);
      rst_n = 1'b0;
      #1;
      check("abort_bus", {bus.mem_a_o[22:0], bus.mem_dout_o,
                          bus.mem_wr_o}, 32'd0);
      bus.ram_w_req_i = 1'b0;
      repeat (2) begin
         @(posedge clk_in);
         #1;
         check("abort_done", {30'd0, bus.ram_done_o, bus.if_done_o},
               32'd0);
         check("abort_wr", 32'(bus.mem_wr_o), 32'd0);
      end
      check("abort_rdata", bus.ram_r_data_o, 32'd0);
      check("abort_idata", bus.if_data_o, 32'd0);
      check("abort_b0", 32'(ram[12'h040]), 32'h44);
      check("abort_b1", 32'(ram[12'h041]), 32'(pat(12'h041)));
      ref_mem[12'h040] = 8'h44;
      exp_rd = 32'd0;
      exp_if = 32'd0;
      rd_ok  = 1'b1;
      rst_n  = 1'b1;
      run(1, 32'h40, 32'd0, 2'b11);

      run(0, 32'hFFFFFFFE, 32'hCAFEF00D, 2'b11);
      run(1, 32'hFFFFFFFE, 32'd0, 2'b11);
      check("wrap_data", bus.ram_r_data_o, 32'hCAFEF00D);

      for (int t = 0; t < 40; t++)
         run(int'($urandom_range(0, 3)),
             32'h800 + 32'($urandom_range(0, 255)),
             $urandom, 2'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
